// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pkg : shared opcodes, FSM state type and result width for alu_cmd_seq  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam int RESULT_W = 8;
  localparam int OP_W     = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_OR  = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_8bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_8bit : combinational 8-bit ALU, truncating arithmetic, logical shifts  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_8bit
  import alu_pkg::*;
(
  input  logic [RESULT_W-1:0] a,
  input  logic [RESULT_W-1:0] b,
  input  logic [OP_W-1:0]     sel,
  output logic [RESULT_W-1:0] result
);

  always_comb begin
    result = '0;
    case (sel)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOT:  result = ~a;
      OP_SHL:  result = a << 1;
      OP_SHR:  result = a >> 1;
      default: result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_cmd_seq : command FIFO feeding a registered ALU with valid/ready output |
// | Optional flags out_zero/out_carry built only when ALU_FLAGS_EN is defined.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RESULT_W-1:0] in_A,
  input  logic [RESULT_W-1:0] in_B,
  input  logic [OP_W-1:0]     in_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RESULT_W-1:0] out_result
`ifdef ALU_FLAGS_EN
  ,
  output logic                out_zero,
  output logic                out_carry
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CMD_W = OP_W + 2 * RESULT_W;

  logic [CMD_W-1:0]    r_fifo_mem [FIFO_DEPTH];
  logic [AW:0]         r_wr_ptr;
  logic [AW:0]         r_rd_ptr;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [CMD_W-1:0]    w_head;
  state_t              r_state;
  logic [RESULT_W-1:0] r_op_a;
  logic [RESULT_W-1:0] r_op_b;
  logic [OP_W-1:0]     r_op_sel;
  logic [RESULT_W-1:0] w_alu_result;

  // Full/empty depend only on registered pointers, so in_ready has no path from the ports.
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_pop    = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready));
  assign w_head   = r_fifo_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr[AW-1:0]] <= {in_sel, in_A, in_B};
  end

  alu_8bit u_alu (
    .a      (r_op_a),
    .b      (r_op_b),
    .sel    (r_op_sel),
    .result (w_alu_result)
  );

`ifdef ALU_FLAGS_EN
  logic w_carry;

  always_comb begin
    w_carry = 1'b0;
    case (r_op_sel)
      OP_ADD:  w_carry = ({1'b0, r_op_a} + {1'b0, r_op_b}) > {1'b0, {RESULT_W{1'b1}}};
      OP_SUB:  w_carry = r_op_a < r_op_b;
      OP_MUL:  w_carry = ({{RESULT_W{1'b0}}, r_op_a} * {{RESULT_W{1'b0}}, r_op_b})
                         > {{RESULT_W{1'b0}}, {RESULT_W{1'b1}}};
      OP_SHL:  w_carry = r_op_a[RESULT_W-1];
      OP_SHR:  w_carry = r_op_a[0];
      default: w_carry = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_sel   <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
`ifdef ALU_FLAGS_EN
      out_zero   <= 1'b0;
      out_carry  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            {r_op_sel, r_op_a, r_op_b} <= w_head;
            r_state                    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_result <= w_alu_result;
          out_valid  <= 1'b1;
`ifdef ALU_FLAGS_EN
          out_zero   <= (w_alu_result == '0);
          out_carry  <= w_carry;
`endif
          r_state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!w_empty) begin
              {r_op_sel, r_op_a, r_op_b} <= w_head;
              r_state                    <= ST_EXEC;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_cmd_seq : self-checking bench with scoreboard and golden ALU model  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_cmd_seq;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_A = '0;
  logic [7:0] in_B = '0;
  logic [2:0] in_sel = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
`ifdef ALU_FLAGS_EN
  logic       out_zero;
  logic       out_carry;
`endif

  int tests = 0;
  int fails = 0;
  int accepted = 0;
  int out_count = 0;
  logic [8:0] exp_q[$];
  logic       hold_prev = 1'b0;
  logic [7:0] hold_val = '0;

  always #5 clk = ~clk;

  alu_cmd_seq #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_A       (in_A),
    .in_B       (in_B),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
`ifdef ALU_FLAGS_EN
    ,
    .out_zero   (out_zero),
    .out_carry  (out_carry)
`endif
  );

  // Golden model: {carry, result} from plain integer arithmetic.
  function automatic logic [8:0] golden(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] s);
    int ua, ub, r;
    logic c;
    ua = int'(a);
    ub = int'(b);
    r = 0;
    c = 1'b0;
    case (s)
      3'd0: begin r = ua + ub; c = (r > 255); end
      3'd1: begin r = ua - ub + 256; c = (ua < ub); end
      3'd2: begin r = ua * ub; c = (r > 255); end
      3'd3: r = int'(a & b);
      3'd4: r = int'(a | b);
      3'd5: r = 255 - ua;
      3'd6: begin r = ua * 2; c = (ua >= 128); end
      default: begin r = ua / 2; c = (ua % 2) == 1; end
    endcase
    return {c, 8'(r % 256)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard: records accepted commands and checks every delivered result.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 16'(out_valid), 16'd1);
        check("hold_stable", 16'(out_result), 16'(hold_val));
      end
      if (out_valid && out_ready) begin
        out_count++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL spurious_result: got %h, required no result", out_result);
        end else begin
          e = exp_q.pop_front();
          if (out_result !== e[7:0]) begin
            fails++;
            $display("FAIL sb_result: got %h, required %h", out_result, e[7:0]);
          end
`ifdef ALU_FLAGS_EN
          check("sb_carry", 16'(out_carry), 16'(e[8]));
          check("sb_zero", 16'(out_zero), 16'(e[7:0] == 8'h00));
`endif
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(golden(in_A, in_B, in_sel));
        accepted++;
      end
      hold_prev = out_valid && !out_ready;
      hold_val  = out_result;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    int n;
    n = 0;
    in_A = a; in_B = b; in_sel = s; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: got in_ready 0, required 1 within 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got out_valid 0, required 1", name);
    end
  endtask

  task automatic run_one(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] s, input logic [7:0] er, input logic ec, input logic ez);
    send(a, b, s);
    wait_valid(name);
    check(name, 16'(out_result), 16'(er));
`ifdef ALU_FLAGS_EN
    check({name, "_carry"}, 16'(out_carry), 16'(ec));
    check({name, "_zero"}, 16'(out_zero), 16'(ez));
`else
    if (ec === ez) begin end
`endif
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acc, base_out;
    logic done;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 16'(out_valid), 16'd0);
    check("reset_out_result", 16'(out_result), 16'h00);
    check("reset_in_ready", 16'(in_ready), 16'd1);
`ifdef ALU_FLAGS_EN
    check("reset_zero", 16'(out_zero), 16'd0);
    check("reset_carry", 16'(out_carry), 16'd0);
`endif

    check("model_add", 16'(golden(8'h0F, 8'h01, OP_ADD)), 16'h010);
    check("model_add_wrap", 16'(golden(8'hFF, 8'h01, OP_ADD)), 16'h100);
    check("model_sub", 16'(golden(8'h03, 8'h05, OP_SUB)), 16'h1FE);
    check("model_mul", 16'(golden(8'h10, 8'h20, OP_MUL)), 16'h100);
    check("model_shr", 16'(golden(8'h81, 8'h00, OP_SHR)), 16'h140);

    // Latency: accept at edge k, out_valid must appear right after edge k+2.
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_A = 8'h0F; in_B = 8'h01; in_sel = OP_ADD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_after_k", 16'(out_valid), 16'd0);
    @(negedge clk);
    check("lat_after_k1", 16'(out_valid), 16'd0);
    @(negedge clk);
    check("lat_after_k2", 16'(out_valid), 16'd1);
    check("lat_result", 16'(out_result), 16'h10);
`ifdef ALU_FLAGS_EN
    check("lat_zero", 16'(out_zero), 16'd0);
    check("lat_carry", 16'(out_carry), 16'd0);
`endif
    @(posedge clk); #1;

    run_one("add_wrap", 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b1);
    run_one("sub_borrow", 8'h03, 8'h05, OP_SUB, 8'hFE, 1'b1, 1'b0);
    run_one("mul_trunc", 8'h10, 8'h20, OP_MUL, 8'h00, 1'b1, 1'b1);
    run_one("shl", 8'h81, 8'h00, OP_SHL, 8'h02, 1'b1, 1'b0);
    run_one("not", 8'h5A, 8'h00, OP_NOT, 8'hA5, 1'b0, 1'b0);

    // Back-pressure: five commands fill FIFO plus operand stage.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(i * 37 + 5), 8'(i + 3), 3'(i));
    @(negedge clk);
    check("full_in_ready", 16'(in_ready), 16'd0);
    @(posedge clk); #1;
    in_A = 8'h77; in_B = 8'h11; in_sel = OP_OR; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_blocks_push", 16'(in_ready), 16'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h77, 8'h11, OP_OR);
    drain("drain_in_order");

    // Reset while holding a result with two commands queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(i + 1), 8'h02, OP_MUL);
    wait_valid("hold_before_rst");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_hold_out_valid", 16'(out_valid), 16'd0);
    check("rst_hold_in_ready", 16'(in_ready), 16'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    base_out = out_count;
    repeat (10) @(negedge clk);
    check("rst_no_results", 16'(out_count - base_out), 16'd0);

    // Randomized traffic with random back-pressure.
    @(posedge clk); #1;
    base_acc = accepted;
    base_out = out_count;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(8'($urandom), 8'($urandom), 3'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("rand_drain");
    check("rand_accepted", 16'(accepted - base_acc), 16'd1000);
    check("rand_delivered", 16'(out_count - base_out), 16'd1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
